// File: rtl/ercm8_div16_if.sv
// Operand/result handshake bundle for the 16-by-8 restoring divider.
`timescale 1ns/1ps
interface ercm8_div16_if;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] dat_in_p;
    logic [7:0]  dat_in_b;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  dat_o_q;
    logic [7:0]  dat_o_r;
    logic        err_dz;
    logic        err_ovf;

    modport slave (
        input  in_valid, dat_in_p, dat_in_b, out_ready,
        output in_ready, out_valid, dat_o_q, dat_o_r, err_dz, err_ovf
    );

    modport master (
        output in_valid, dat_in_p, dat_in_b, out_ready,
        input  in_ready, out_valid, dat_o_q, dat_o_r, err_dz, err_ovf
    );
endinterface

// File: rtl/ercm8_div16.sv
// Sequential 16/8 unsigned restoring divider, one quotient bit per cycle,
// with divide-by-zero and quotient-overflow detection at operand capture.
`timescale 1ns/1ps
module ercm8_div16 (
    input  logic             clk,
    input  logic             rst_n,
    ercm8_div16_if.slave     bus
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t      r_state;
    logic [7:0]  r_rem;
    logic [7:0]  r_quo;
    logic [7:0]  r_div;
    logic [2:0]  r_cnt;
    logic        r_in_ready;
    logic        r_out_valid;
    logic [7:0]  r_q_out;
    logic [7:0]  r_r_out;
    logic        r_err_dz;
    logic        r_err_ovf;

    logic [8:0]  w_t;
    logic        w_ge;
    logic [7:0]  w_diff;
    logic [7:0]  w_rem_nxt;
    logic [7:0]  w_quo_nxt;

    // R < B keeps T - B below B, so an 8-bit subtraction is exact
    always_comb begin
        w_t       = {r_rem, r_quo[7]};
        w_ge      = (w_t >= {1'b0, r_div});
        w_diff    = w_t[7:0] - r_div;
        w_rem_nxt = w_t[7:0];
        w_quo_nxt = {r_quo[6:0], 1'b0};
        if (w_ge) begin
            w_rem_nxt = w_diff;
            w_quo_nxt = {r_quo[6:0], 1'b1};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_rem       <= '0;
            r_quo       <= '0;
            r_div       <= '0;
            r_cnt       <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_q_out     <= '0;
            r_r_out     <= '0;
            r_err_dz    <= 1'b0;
            r_err_ovf   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.in_valid) begin
                        r_in_ready <= 1'b0;
                        if (bus.dat_in_b == '0) begin
                            r_state     <= DONE;
                            r_out_valid <= 1'b1;
                            r_q_out     <= '1;
                            r_r_out     <= bus.dat_in_p[7:0];
                            r_err_dz    <= 1'b1;
                            r_err_ovf   <= 1'b0;
                        end else if (bus.dat_in_p[15:8] >= bus.dat_in_b) begin
                            r_state     <= DONE;
                            r_out_valid <= 1'b1;
                            r_q_out     <= '1;
                            r_r_out     <= '1;
                            r_err_dz    <= 1'b0;
                            r_err_ovf   <= 1'b1;
                        end else begin
                            r_state   <= CALC;
                            r_rem     <= bus.dat_in_p[15:8];
                            r_quo     <= bus.dat_in_p[7:0];
                            r_div     <= bus.dat_in_b;
                            r_cnt     <= '0;
                            r_err_dz  <= 1'b0;
                            r_err_ovf <= 1'b0;
                        end
                    end
                end
                CALC: begin
                    r_rem <= w_rem_nxt;
                    r_quo <= w_quo_nxt;
                    r_cnt <= r_cnt + 3'd1;
                    if (r_cnt == 3'd7) begin
                        r_state     <= DONE;
                        r_out_valid <= 1'b1;
                        r_q_out     <= w_quo_nxt;
                        r_r_out     <= w_rem_nxt;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        r_state     <= IDLE;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.dat_o_q   = r_q_out;
    assign bus.dat_o_r   = r_r_out;
    assign bus.err_dz    = r_err_dz;
    assign bus.err_ovf   = r_err_ovf;
endmodule

// File: tb/tb_ercm8_div16.sv
// Directed bench for ercm8_div16: vector table plus backpressure and mid-op reset sequences.
`timescale 1ns/1ps
module tb_ercm8_div16;
    logic clk;
    logic rst_n;
    ercm8_div16_if bus();

    ercm8_div16 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] p;
        logic [7:0]  b;
        logic [7:0]  q;
        logic [7:0]  r;
        logic        dz;
        logic        ovf;
        int unsigned lat;
    } vec_t;

    vec_t vecs[11];
    int unsigned n_err;
    int unsigned n_chk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives one operation, measures latency to out_valid, checks the result.
    // When release_now is set, out_ready is already high and the drop is checked.
    task automatic run_op(input vec_t v, input bit release_now);
        int unsigned cyc;
        bus.dat_in_p = v.p;
        bus.dat_in_b = v.b;
        bus.in_valid = 1'b1;
        chk("in_ready_before", {15'd0, bus.in_ready}, 16'd1);
        step();
        bus.in_valid = 1'b0;
        bus.dat_in_p = 16'hDEAD;
        bus.dat_in_b = 8'hBE;
        cyc = 1;
        while (!bus.out_valid && cyc < 20) begin
            chk("in_ready_busy", {15'd0, bus.in_ready}, 16'd0);
            step();
            cyc++;
        end
        chk("latency", cyc[15:0], v.lat[15:0]);
        chk("in_ready_done", {15'd0, bus.in_ready}, 16'd0);
        chk("quotient", {8'd0, bus.dat_o_q}, {8'd0, v.q});
        chk("remainder", {8'd0, bus.dat_o_r}, {8'd0, v.r});
        chk("err_dz", {15'd0, bus.err_dz}, {15'd0, v.dz});
        chk("err_ovf", {15'd0, bus.err_ovf}, {15'd0, v.ovf});
        if (release_now) begin
            step();
            chk("out_valid_drop", {15'd0, bus.out_valid}, 16'd0);
            chk("in_ready_back", {15'd0, bus.in_ready}, 16'd1);
        end
    endtask

    initial begin
        vec_t v;
        n_err = 0;
        n_chk = 0;
        vecs[0]  = '{16'd45000,  8'd200, 8'd225,  8'd0,    1'b0, 1'b0, 9};
        vecs[1]  = '{16'd1234,   8'd7,   8'd176,  8'd2,    1'b0, 1'b0, 9};
        vecs[2]  = '{16'd65279,  8'd255, 8'd255,  8'd254,  1'b0, 1'b0, 9};
        vecs[3]  = '{16'h1234,   8'h00,  8'hFF,   8'h34,   1'b1, 1'b0, 1};
        vecs[4]  = '{16'h1000,   8'h10,  8'hFF,   8'hFF,   1'b0, 1'b1, 1};
        vecs[5]  = '{16'h0FFF,   8'h10,  8'hFF,   8'h0F,   1'b0, 1'b0, 9};
        vecs[6]  = '{16'd0,      8'd1,   8'd0,    8'd0,    1'b0, 1'b0, 9};
        vecs[7]  = '{16'h00FF,   8'd1,   8'd255,  8'd0,    1'b0, 1'b0, 9};
        vecs[8]  = '{16'hFFFF,   8'hFF,  8'hFF,   8'hFF,   1'b0, 1'b1, 1};
        vecs[9]  = '{16'd100,    8'd200, 8'd0,    8'd100,  1'b0, 1'b0, 9};
        vecs[10] = '{16'h0000,   8'h00,  8'hFF,   8'h00,   1'b1, 1'b0, 1};

        rst_n = 1'b0;
        bus.in_valid  = 1'b0;
        bus.dat_in_p  = '0;
        bus.dat_in_b  = '0;
        bus.out_ready = 1'b1;
        step();
        chk("rst_in_ready", {15'd0, bus.in_ready}, 16'd1);
        chk("rst_out_valid", {15'd0, bus.out_valid}, 16'd0);
        chk("rst_q", {8'd0, bus.dat_o_q}, 16'd0);
        chk("rst_r", {8'd0, bus.dat_o_r}, 16'd0);
        chk("rst_flags", {14'd0, bus.err_dz, bus.err_ovf}, 16'd0);
        rst_n = 1'b1;
        step();

        // out_ready held high: back-to-back operations from the table
        for (int i = 0; i < 11; i++) begin
            run_op(vecs[i], 1'b1);
        end

        // Backpressure: 500 / 7 = 71 r 3, held for 5 cycles
        bus.out_ready = 1'b0;
        v = '{16'd500, 8'd7, 8'd71, 8'd3, 1'b0, 1'b0, 9};
        run_op(v, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_out_valid", {15'd0, bus.out_valid}, 16'd1);
            chk("bp_in_ready", {15'd0, bus.in_ready}, 16'd0);
            chk("bp_q", {8'd0, bus.dat_o_q}, 16'd71);
            chk("bp_r", {8'd0, bus.dat_o_r}, 16'd3);
        end
        bus.out_ready = 1'b1;
        step();
        chk("bp_release_valid", {15'd0, bus.out_valid}, 16'd0);
        chk("bp_release_ready", {15'd0, bus.in_ready}, 16'd1);

        // Reset pulse during CALC cycle 4 aborts the operation
        bus.dat_in_p = 16'd45000;
        bus.dat_in_b = 8'd200;
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        step();
        step();
        step();
        rst_n = 1'b0;
        #1;
        chk("abort_out_valid", {15'd0, bus.out_valid}, 16'd0);
        chk("abort_in_ready", {15'd0, bus.in_ready}, 16'd1);
        chk("abort_q", {8'd0, bus.dat_o_q}, 16'd0);
        chk("abort_r", {8'd0, bus.dat_o_r}, 16'd0);
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step();
            chk("abort_no_result", {15'd0, bus.out_valid}, 16'd0);
        end
        v = '{16'd300, 8'd3, 8'd100, 8'd0, 1'b0, 1'b0, 9};
        run_op(v, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, errors=%0d", n_err);
        $fatal(1);
    end
endmodule
